// File: rtl/seg_serial_tx.sv
// rtl/seg_serial_tx.sv - serial frame transmitter for an eight-digit seven-segment shift-register chain
//
// Purpose:
//   Captures an eight-digit hex value, per-digit decimal points, per-digit blink enables
//   and the current blink phase into shadow registers. It then shifts a 64-bit active-low
//   segment frame (digit 7 first, each byte MSB first) out on seg_clk/seg_dat, and closes
//   the frame with a storage-register latch pulse.
//
// Parameters:
//   CLK_DIV  half-period of seg_clk in clk cycles (1..255)
//   BLINK_W  width of the free-running blink counter; its MSB is the blink phase
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous active-low reset
//   start      frame request, sampled only while idle
//   Disp_num   eight hex digits, digit i = Disp_num[4i+3:4i]
//   LE         per-digit blink enable
//   point      per-digit decimal point, 1 = lit
//   seg_clk    serial shift clock
//   seg_dat    serial data, stable while seg_clk is high
//   seg_latch  storage-register latch pulse (CLK_DIV cycles)
//   busy       high from frame capture until the latch pulse ends
//   done       one-cycle pulse as the frame completes
module seg_serial_tx #(
    parameter int CLK_DIV = 2,
    parameter int BLINK_W = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  LE,
    input  logic [7:0]  point,
    output logic        seg_clk,
    output logic        seg_dat,
    output logic        seg_latch,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'd63;

    // Segment pattern {g,f,e,d,c,b,a}, active-low; the dp bit is added separately.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Full frame; byte i holds digit i so bit 63 is the first bit on the wire.
    function automatic logic [63:0] build_frame(
        input logic [31:0] num,
        input logic [7:0]  le,
        input logic [7:0]  dp,
        input logic        blink
    );
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            if (le[i] && blink) begin
                f[8*i +: 8] = 8'hFF;
            end else begin
                f[8*i +: 8] = {~dp[i], hex_seg(num[4*i +: 4])};
            end
        end
        return f;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         div_q, div_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [31:0]        disp_q, disp_d;
    logic [7:0]         le_q, le_d;
    logic [7:0]         point_q, point_d;
    logic               phase_q, phase_d;
    logic               seg_clk_q, seg_clk_d;
    logic               seg_dat_q, seg_dat_d;
    logic               seg_latch_q, seg_latch_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [63:0]        shadow_frame;
    logic               blink_phase;
    logic               cap_first_bit;
    logic               div_end;
    logic [5:0]         bit_nxt;

    assign blink_phase  = blink_q[BLINK_W-1];
    assign shadow_frame = build_frame(disp_q, le_q, point_q, phase_q);
    assign div_end      = (div_q == DIV_LAST);
    assign bit_nxt      = bit_cnt_q + 6'd1;

    // The first bit on the wire is digit 7's dp bit, or 1 when digit 7 is blanked.
    // It must come straight from the inputs because the shadow registers load
    // on the same edge that drives it out.
    assign cap_first_bit = (LE[7] & blink_phase) | ~point[7];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        blink_d     = blink_q + BLINK_W'(1);
        disp_d      = disp_q;
        le_d        = le_q;
        point_d     = point_q;
        phase_d     = phase_q;
        seg_clk_d   = seg_clk_q;
        seg_dat_d   = seg_dat_q;
        seg_latch_d = seg_latch_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                seg_clk_d   = 1'b0;
                seg_dat_d   = 1'b0;
                seg_latch_d = 1'b0;
                busy_d      = 1'b0;
                if (start) begin
                    disp_d    = Disp_num;
                    le_d      = LE;
                    point_d   = point;
                    phase_d   = blink_phase;
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 6'd0;
                    div_d     = 8'd0;
                    seg_dat_d = cap_first_bit;
                    busy_d    = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (div_end) begin
                    div_d = 8'd0;
                    if (!seg_clk_q) begin
                        seg_clk_d = 1'b1;
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d     = ST_LATCH;
                        seg_clk_d   = 1'b0;
                        seg_dat_d   = 1'b0;
                        seg_latch_d = 1'b1;
                    end else begin
                        // Data changes only as seg_clk falls, so it is stable across the high phase.
                        bit_cnt_d = bit_nxt;
                        seg_clk_d = 1'b0;
                        seg_dat_d = shadow_frame[BIT_LAST - bit_nxt];
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            ST_LATCH: begin
                if (div_end) begin
                    div_d       = 8'd0;
                    state_d     = ST_IDLE;
                    seg_latch_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                div_d       = 8'd0;
                bit_cnt_d   = 6'd0;
                seg_clk_d   = 1'b0;
                seg_dat_d   = 1'b0;
                seg_latch_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            div_q       <= '0;
            blink_q     <= '0;
            disp_q      <= '0;
            le_q        <= '0;
            point_q     <= '0;
            phase_q     <= 1'b0;
            seg_clk_q   <= 1'b0;
            seg_dat_q   <= 1'b0;
            seg_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            blink_q     <= blink_d;
            disp_q      <= disp_d;
            le_q        <= le_d;
            point_q     <= point_d;
            phase_q     <= phase_d;
            seg_clk_q   <= seg_clk_d;
            seg_dat_q   <= seg_dat_d;
            seg_latch_q <= seg_latch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign seg_clk   = seg_clk_q;
    assign seg_dat   = seg_dat_q;
    assign seg_latch = seg_latch_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
